// File: rtl/meta_info_streamer_if.sv
// Byte stream bundle between the meta-info streamer and its consumer.
// master drives out_data/out_valid, slave drives out_ready.
interface meta_info_streamer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/meta_info_streamer.sv
// Walks one project's meta-info string in the character ROM, waits a settle
// time per address and emits each character on a valid/ready byte stream.
// Ports: clock, reset (sync, active-low); start/proj_idx request;
// busy/done status; rom_proj_idx/rom_chr_idx -> ROM, rom_chr <- ROM;
// stream (out_data/out_valid/out_ready); chars_sent = chars delivered.
module meta_info_streamer #(
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_CHARS     = 63,
    parameter bit APPEND_NL     = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           proj_idx,
    output logic                 busy,
    output logic                 done,
    output logic [5:0]           rom_proj_idx,
    output logic [5:0]           rom_chr_idx,
    input  logic [7:0]           rom_chr,
    output logic [6:0]           chars_sent,
    meta_info_streamer_if.master stream
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);
    localparam logic [5:0] LAST_IDX = 6'(MAX_CHARS - 1);
    localparam logic [7:0] NL_CHR = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SEND,
        TERM,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [5:0]    proj_nxt;
    logic [5:0]    chr_nxt;
    logic [6:0]    sent_nxt;
    logic [7:0]    data_nxt;
    logic          valid_nxt;
    logic          xfer;

    assign xfer = stream.out_valid && stream.out_ready;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            rom_proj_idx     <= '0;
            rom_chr_idx      <= '0;
            chars_sent       <= '0;
            stream.out_data  <= '0;
            stream.out_valid <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            rom_proj_idx     <= proj_nxt;
            rom_chr_idx      <= chr_nxt;
            chars_sent       <= sent_nxt;
            stream.out_data  <= data_nxt;
            stream.out_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        proj_nxt  = rom_proj_idx;
        chr_nxt   = rom_chr_idx;
        sent_nxt  = chars_sent;
        data_nxt  = stream.out_data;
        valid_nxt = stream.out_valid;
        unique case (state)
            IDLE: begin
                if (start) begin
                    proj_nxt  = proj_idx;
                    chr_nxt   = '0;
                    sent_nxt  = '0;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // ROM data is only trusted once the counter has run out
                if (cnt == '0) begin
                    if (rom_chr == 8'h00) begin
                        state_nxt = TERM;
                    end else begin
                        data_nxt  = rom_chr;
                        valid_nxt = 1'b1;
                        state_nxt = SEND;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SEND: begin
                if (xfer) begin
                    sent_nxt  = chars_sent + 7'd1;
                    valid_nxt = 1'b0;
                    // stop at the length limit instead of wrapping the index
                    if (rom_chr_idx == LAST_IDX) begin
                        state_nxt = TERM;
                    end else begin
                        chr_nxt   = rom_chr_idx + 6'd1;
                        cnt_nxt   = CNT_INIT;
                        state_nxt = WAIT;
                    end
                end
            end
            TERM: begin
                // entered with out_valid low; raise the newline, then wait
                if (!APPEND_NL) begin
                    state_nxt = DONE;
                end else if (!stream.out_valid) begin
                    data_nxt  = NL_CHR;
                    valid_nxt = 1'b1;
                end else if (stream.out_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_meta_info_streamer.sv
// Randomized self-checking bench for meta_info_streamer with a ROM model
// and a string-level reference model; also covers the APPEND_NL=0 variant.
module tb_meta_info_streamer;
    localparam int SC  = 8;
    localparam int MC  = 63;
    localparam int SCN = 2;
    localparam int MCN = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [5:0] proj_idx = '0;
    logic       busy;
    logic       done;
    logic [5:0] rom_proj_idx;
    logic [5:0] rom_chr_idx;
    logic [7:0] rom_chr;
    logic [6:0] chars_sent;

    logic       start_n = 1'b0;
    logic [5:0] proj_n = '0;
    logic       busy_n;
    logic       done_n;
    logic [5:0] rpi_n;
    logic [5:0] rci_n;
    logic [7:0] rom_chr_n;
    logic [6:0] chars_n;

    logic [7:0] rom [64][64];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] gotn_q[$];
    logic [7:0] exp_q[$];
    int         rise_q[$];
    int         exp_cnt;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = '0;

    meta_info_streamer_if s_if ();
    meta_info_streamer_if n_if ();

    assign rom_chr   = rom[rom_proj_idx][rom_chr_idx];
    assign rom_chr_n = rom[rpi_n][rci_n];

    meta_info_streamer #(
        .SETTLE_CYCLES(SC),
        .MAX_CHARS(MC),
        .APPEND_NL(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .proj_idx(proj_idx),
        .busy(busy),
        .done(done),
        .rom_proj_idx(rom_proj_idx),
        .rom_chr_idx(rom_chr_idx),
        .rom_chr(rom_chr),
        .chars_sent(chars_sent),
        .stream(s_if.master)
    );

    meta_info_streamer #(
        .SETTLE_CYCLES(SCN),
        .MAX_CHARS(MCN),
        .APPEND_NL(1'b0)
    ) dut_n (
        .clock(clock),
        .reset(reset),
        .start(start_n),
        .proj_idx(proj_n),
        .busy(busy_n),
        .done(done_n),
        .rom_proj_idx(rpi_n),
        .rom_chr_idx(rci_n),
        .rom_chr(rom_chr_n),
        .chars_sent(chars_n),
        .stream(n_if.master)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // main stream monitor: collects transfers, checks hold rules
    always @(negedge clock) begin
        if (!reset) begin
            pv <= 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_valid", 32'(s_if.out_valid), 32'd1);
                check("hold_data", 32'(s_if.out_data), 32'(pd));
            end
            if (s_if.out_valid && !pv) rise_q.push_back(cyc);
            if (s_if.out_valid && s_if.out_ready)
                got_q.push_back(s_if.out_data);
            if (done) begin
                done_cnt <= done_cnt + 1;
                check("done_busy", 32'(busy), 32'd1);
                check("done_novalid", 32'(s_if.out_valid), 32'd0);
            end
            pv <= s_if.out_valid;
            pr <= s_if.out_ready;
            pd <= s_if.out_data;
        end
    end

    always @(negedge clock) begin
        if (reset && n_if.out_valid && n_if.out_ready)
            gotn_q.push_back(n_if.out_data);
    end

    // reference: characters up to NUL or the length limit, then terminator
    task automatic build_exp(input int p, input int maxc, input bit nl);
        exp_q.delete();
        exp_cnt = 0;
        for (int i = 0; i < maxc; i++) begin
            if (rom[p][i] == 8'h00) break;
            exp_q.push_back(rom[p][i]);
            exp_cnt++;
        end
        if (nl) exp_q.push_back(8'h0A);
    endtask

    // rmode: 0 ready high, 1 random ready, 2 20-cycle stall on 2nd byte
    task automatic run_msg(input logic [5:0] p, input int rmode,
                           input bit noise);
        int t0;
        int td;
        int n;
        int d0;
        int lat;
        bit stalled;
        logic [5:0] hold_idx;
        build_exp(int'(p), MC, 1'b1);
        got_q.delete();
        rise_q.delete();
        d0 = done_cnt;
        s_if.out_ready = 1'b1;
        proj_idx = p;
        start = 1'b1;
        @(posedge clock);
        #1;
        t0 = cyc;
        start = 1'b0;
        check("busy_on_start", 32'(busy), 32'd1);
        n = 0;
        stalled = 1'b0;
        while (!done && n < 5000) begin
            if (noise) begin
                start = 1'($urandom);
                proj_idx = 6'($urandom);
            end
            if (rmode == 1) s_if.out_ready = 1'($urandom);
            if (rmode == 2 && !stalled && got_q.size() == 1 &&
                s_if.out_valid) begin
                stalled = 1'b1;
                s_if.out_ready = 1'b0;
                hold_idx = rom_chr_idx;
                repeat (20) begin
                    @(posedge clock);
                    #1;
                end
                check("stall_idx", 32'(rom_chr_idx), 32'(hold_idx));
                check("stall_valid", 32'(s_if.out_valid), 32'd1);
                s_if.out_ready = 1'b1;
            end
            @(posedge clock);
            #1;
            n++;
        end
        td = cyc;
        check("done_seen", 32'(done), 32'd1);
        // a start presented during DONE must be ignored
        start = noise;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("idle_after_done", 32'(busy), 32'd0);
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("byte", 32'(got_q[i]), 32'(exp_q[i]));
        check("chars_sent", 32'(chars_sent), 32'(exp_cnt));
        check("proj_latched", 32'(rom_proj_idx), 32'(p));
        check("last_idx", 32'(rom_chr_idx),
              32'((exp_cnt == MC) ? MC - 1 : exp_cnt));
        if (rmode == 0) begin
            lat = (exp_cnt == MC) ? exp_cnt * (SC + 1) + 2
                                  : exp_cnt * (SC + 1) + SC + 2;
            check("done_latency", 32'(td - t0), 32'(lat));
            if (exp_cnt >= 2 && rise_q.size() >= 2) begin
                check("first_valid", 32'(rise_q[0] - t0), 32'(SC));
                check("second_valid", 32'(rise_q[1] - t0), 32'(2 * SC + 1));
            end
        end
    endtask

    task automatic run_nl(input logic [5:0] p);
        int t0;
        int n;
        int lat;
        build_exp(int'(p), MCN, 1'b0);
        gotn_q.delete();
        proj_n = p;
        start_n = 1'b1;
        @(posedge clock);
        #1;
        t0 = cyc;
        start_n = 1'b0;
        n = 0;
        while (!done_n && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("nl_done_seen", 32'(done_n), 32'd1);
        lat = (exp_cnt == MCN) ? exp_cnt * (SCN + 1) + 1
                               : exp_cnt * (SCN + 1) + SCN + 1;
        check("nl_done_latency", 32'(cyc - t0), 32'(lat));
        @(posedge clock);
        #1;
        check("nl_idle", 32'(busy_n), 32'd0);
        check("nl_nbytes", 32'(gotn_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < gotn_q.size(); i++)
            check("nl_byte", 32'(gotn_q[i]), 32'(exp_q[i]));
        check("nl_chars_sent", 32'(chars_n), 32'(exp_cnt));
        check("nl_last_idx", 32'(rci_n),
              32'((exp_cnt == MCN) ? MCN - 1 : exp_cnt));
    endtask

    initial begin
        int d0;
        int n;
        int len;
        for (int p = 0; p < 64; p++) begin
            len = $urandom_range(0, 70);
            for (int i = 0; i < 64; i++)
                rom[p][i] = 8'($urandom_range(1, 255));
            if (len < 64) rom[p][len] = 8'h00;
        end
        rom[5][0] = 8'h41;
        rom[5][1] = 8'h42;
        rom[5][2] = 8'h43;
        rom[5][3] = 8'h00;
        rom[0][0] = 8'h00;
        for (int i = 0; i < 64; i++)
            rom[63][i] = 8'($urandom_range(1, 255));
        s_if.out_ready = 1'b1;
        n_if.out_ready = 1'b1;

        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(s_if.out_valid), 32'd0);
        check("rst_data", 32'(s_if.out_data), 32'd0);
        check("rst_proj", 32'(rom_proj_idx), 32'd0);
        check("rst_chr", 32'(rom_chr_idx), 32'd0);
        check("rst_sent", 32'(chars_sent), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        run_msg(6'd5, 0, 1'b0);
        run_msg(6'd0, 0, 1'b0);
        run_msg(6'd63, 0, 1'b0);
        run_msg(6'd5, 2, 1'b0);
        run_msg(6'd63, 2, 1'b1);
        run_msg(6'd5, 0, 1'b1);
        for (int k = 0; k < 12; k++)
            run_msg(6'($urandom), $urandom_range(0, 1), 1'($urandom));

        // reset while a character is waiting for the consumer
        s_if.out_ready = 1'b0;
        proj_idx = 6'd5;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 0;
        while (!s_if.out_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("rst_in_send", 32'(s_if.out_valid), 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_valid", 32'(s_if.out_valid), 32'd0);
        check("abort_data", 32'(s_if.out_data), 32'd0);
        check("abort_proj", 32'(rom_proj_idx), 32'd0);
        check("abort_chr", 32'(rom_chr_idx), 32'd0);
        check("abort_sent", 32'(chars_sent), 32'd0);
        d0 = done_cnt;
        got_q.delete();
        s_if.out_ready = 1'b1;
        repeat (30) begin
            @(posedge clock);
            #1;
        end
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_no_bytes", 32'(got_q.size()), 32'd0);
        run_msg(6'd5, 0, 1'b0);

        run_nl(6'd0);
        run_nl(6'd5);
        run_nl(6'd63);
        for (int k = 0; k < 4; k++)
            run_nl(6'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
